// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the program-memory read port, the redirect request and the
// instruction handshake toward decode.
//   master : the fetch unit (drives MEM_ADDR/MEM_RE and IR_VALID/IR/IR_PC)
//   slave  : memory + decode side (drives MEM_RDATA, REDIRECT*, IR_READY)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] MEM_ADDR;
   logic              MEM_RE;
   logic [7:0]        MEM_RDATA;
   logic              REDIRECT;
   logic [ADDR_W-1:0] REDIRECT_PC;
   logic              IR_VALID;
   logic              IR_READY;
   logic [15:0]       IR;
   logic [ADDR_W-1:0] IR_PC;

   modport master (
      output MEM_ADDR, MEM_RE, IR_VALID, IR, IR_PC,
      input  MEM_RDATA, REDIRECT, REDIRECT_PC, IR_READY
   );

   modport slave (
      input  MEM_ADDR, MEM_RE, IR_VALID, IR, IR_PC,
      output MEM_RDATA, REDIRECT, REDIRECT_PC, IR_READY
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches 16-bit big-endian instructions from a byte-wide asynchronous-read
// program memory (two reads per instruction) and queues them, with their PCs,
// toward decode over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the (even-aligned) target.
// Ports:
//   CK     : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : instr_fetch_unit_if.master
//            MEM_ADDR/MEM_RE/MEM_RDATA    program memory read port
//            REDIRECT/REDIRECT_PC         flush + new fetch address
//            IR_VALID/IR_READY/IR/IR_PC   instruction queue head toward decode
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                CK,
   input  logic                RST_N,
   instr_fetch_unit_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_HI = 1'b0, S_LO = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [7:0]        hi_q, hi_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [15:0]       ir_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q [DEPTH];

   logic room;
   logic push;
   logic pop;

   // Slot is reserved in S_HI on the current count only; a pop in the same
   // cycle does not free room until the next cycle.
   assign room = (count_q < CNT_W'(DEPTH));
   assign push = (state_q == S_LO) && !bus.REDIRECT;
   assign pop  = (count_q != '0) && bus.IR_READY && !bus.REDIRECT;

   // ---- FSM: state register ----
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) state_q <= S_HI;
      else        state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      if (bus.REDIRECT) begin
         state_d = S_HI;
      end else begin
         case (state_q)
            S_HI:    if (room) state_d = S_LO;
            S_LO:    state_d = S_HI;
            default: state_d = S_HI;
         endcase
      end
   end

   // ---- FSM: outputs ----
   always_comb begin
      bus.MEM_ADDR = fetch_pc_q;
      bus.MEM_RE   = 1'b0;
      case (state_q)
         S_HI: begin
            bus.MEM_ADDR = fetch_pc_q;
            bus.MEM_RE   = room;
         end
         S_LO: begin
            bus.MEM_ADDR = fetch_pc_q + ADDR_W'(1);
            bus.MEM_RE   = 1'b1;
         end
         default: ;
      endcase
      // Strobe is forced low while reset is held, with no edge required.
      bus.MEM_RE = bus.MEM_RE & RST_N;
   end

   // ---- datapath next state ----
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      hi_d       = hi_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (bus.REDIRECT) begin
         // Odd targets are aligned down to the instruction boundary.
         fetch_pc_d = bus.REDIRECT_PC & ~ADDR_W'(1);
         hi_d       = '0;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (state_q == S_HI && room) hi_d = bus.MEM_RDATA;
         if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
            tail_d     = tail_q + PTR_W'(1);
         end
         if (pop) head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         fetch_pc_q <= RESET_PC;
         hi_q       <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         hi_q       <= hi_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Queue storage; cleared on reset so IR/IR_PC read 0 out of reset.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            ir_mem_q[i] <= '0;
            pc_mem_q[i] <= '0;
         end
      end else if (push) begin
         ir_mem_q[tail_q] <= {hi_q, bus.MEM_RDATA};
         pc_mem_q[tail_q] <= fetch_pc_q;
      end
   end

   assign bus.IR_VALID = (count_q != '0);
   assign bus.IR       = ir_mem_q[head_q];
   assign bus.IR_PC    = pc_mem_q[head_q];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 16-bit CPU decode/execute stage. It supplies the CPU's IR.
- Reads the byte-wide program memory two bytes per instruction. Big-endian: mem[pc] is IR[15:8], mem[pc+1] is IR[7:0].
- Buffers assembled instructions, with their PCs, in a small queue toward decode using a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and restarts fetch.

Parameters:
- ADDR_W, 8, byte address width of program memory and of the PC.
- DEPTH, 4, instruction queue entries (power of 2, at least 2).
- RESET_PC, 0, fetch address after reset (even).

Ports:
- CK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- MEM_ADDR  out  ADDR_W  byte read address (combinational from state).
- MEM_RE  out  1  read strobe.
- MEM_RDATA  in  8  byte at MEM_ADDR; asynchronous read, valid in the same cycle.
- REDIRECT  in  1  flush and restart fetch.
- REDIRECT_PC  in  ADDR_W  new fetch address.
- IR_VALID  out  1  queue head holds a valid instruction.
- IR_READY  in  1  decode accepts the head this cycle.
- IR  out  16  head instruction.
- IR_PC  out  ADDR_W  byte address of the head instruction.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=S_HI, fetch_pc=RESET_PC, count=0, head/tail=0.
  - Queue storage, hi byte register and PC storage are all cleared to 0.
  - Outputs: IR_VALID=0, IR=0, IR_PC=0, MEM_RE=0 (gated by RST_N), MEM_ADDR=RESET_PC.
- FSM, 2 states:
  - S_HI:
    - MEM_ADDR=fetch_pc. MEM_RE=(count<DEPTH).
    - If MEM_RE is high, latch MEM_RDATA into hi_byte and go to S_LO; else stay in S_HI.
  - S_LO:
    - MEM_ADDR=fetch_pc+1 (mod 2^ADDR_W). MEM_RE=1.
    - Push {hi_byte, MEM_RDATA} with PC=fetch_pc into the queue.
    - Then fetch_pc <= fetch_pc+2 (mod 2^ADDR_W) and go to S_HI.
- Latency and throughput:
  - First IR_VALID rises after the 2nd rising edge following reset release.
  - Steady state is one instruction per 2 cycles.
- Slot reservation:
  - An instruction starts only when count<DEPTH, sampled in S_HI. A pop in that same cycle is not credited.
  - At most one instruction is in flight, so a push never overflows.
- Queue:
  - Circular buffer. IR/IR_PC are combinational from the head entry. IR_VALID=(count!=0).
  - Pop when IR_VALID && IR_READY.
  - Push and pop in the same cycle leave count unchanged.
  - A pop when count==0 is ignored.
- Redirect (sampled at the rising edge, highest priority):
  - count, head and tail go to 0. Any push or pop that cycle is suppressed and hi_byte is discarded.
  - fetch_pc <= {REDIRECT_PC[ADDR_W-1:1],1'b0}, i.e. an odd target has its LSB forced to 0.
  - state <= S_HI. IR_VALID is 0 from the next cycle until the new target's first push.
  - A redirect held for several cycles keeps re-applying; fetch resumes on the first cycle after it drops.
- Wrap-around:
  - The PC and the +1 and +2 increments wrap modulo 2^ADDR_W.
  - An instruction at 2^ADDR_W-2 is followed by one at 0.
- Reset mid-operation:
  - Asserting RST_N low takes effect immediately, with no edge needed; all state returns to reset values.
  - A partial instruction is discarded.
- IR and IR_PC hold stable while IR_VALID=1 and IR_READY=0, except on redirect or reset.

Test Plan:
1. Sequential fetch:
   - Stimulus: mem[0..7]=00,A1,02,23,01,C4,05,E6; IR_READY=1.
   - Response: IR=16'h00A1,16'h0223,16'h01C4,16'h05E6 with IR_PC=0,2,4,6.
   - Timing: first IR_VALID after edge 2; subsequent instructions every 2 cycles.
2. Backpressure and full queue:
   - Stimulus: as scenario 1 but IR_READY=0.
   - Response: after 4 pushes, count=4, MEM_RE=0 and fetch_pc=8; IR stays 16'h00A1.
   - Then IR_READY=1: 4 pops on consecutive cycles in order, and fetch resumes at PC 8.
3. Redirect mid-instruction:
   - Stimulus: assert REDIRECT with REDIRECT_PC=6 while in S_LO of the PC 2 fetch.
   - Response: no 16'h0223 is ever presented, the queue is empty, and the next IR=16'h05E6 with IR_PC=6.
4. Odd redirect target:
   - Stimulus: REDIRECT_PC=5.
   - Response: fetch starts at 4; IR=16'h01C4 with IR_PC=4.
5. Address wrap:
   - Stimulus: RESET_PC=8'hFE, mem[FE]=12, mem[FF]=34.
   - Response: IR=16'h1234 with IR_PC=FE, then IR=16'h00A1 with IR_PC=00.
6. Asynchronous reset:
   - Stimulus: pull RST_N low between clock edges while in S_LO with count=2.
   - Response: IR_VALID=0, IR=0 and MEM_RE=0 immediately, with no clock edge.
   - After release, the first IR is 16'h00A1 from RESET_PC 0.
